// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one 2W accumulator, with a fast path for div special cases.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            MulDivOp_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W = DATA_WIDTH;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [W-1:0] ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0] ONES_W   = {W{1'b1}};
  localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MIN_W    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] CNT_INIT = W'(W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q, state_d;
  logic [W-1:0]     cnt_q, cnt_d, mcand_q, mcand_d, result_q, result_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d, neg_rem_q, neg_rem_d, done_q, done_d;

  logic             a_signed_s, b_signed_s, sign_a_s, sign_b_s, div_zero_s, ovf_s;
  logic [W-1:0]     mag_a_s, mag_b_s, special_res_s;
  logic [W:0]       mul_sum_s, rem_shift_s, div_diff_s;
  logic [2*W-1:0]   mul_acc_s, mul_prod_s;
  logic             div_ge_s;
  logic [W-1:0]     div_rem_s, div_quo_s, div_res_s;

  assign a_signed_s = (MulDivOp_i == OP_MULH) || (MulDivOp_i == OP_MULHSU) ||
                      (MulDivOp_i == OP_DIV)  || (MulDivOp_i == OP_REM);
  assign b_signed_s = (MulDivOp_i == OP_MULH) || (MulDivOp_i == OP_DIV) || (MulDivOp_i == OP_REM);
  assign sign_a_s   = a_signed_s & SrcA_i[W-1];
  assign sign_b_s   = b_signed_s & SrcB_i[W-1];
  assign mag_a_s    = sign_a_s ? neg_w(SrcA_i) : SrcA_i;
  assign mag_b_s    = sign_b_s ? neg_w(SrcB_i) : SrcB_i;
  assign div_zero_s = MulDivOp_i[2] && (SrcB_i == ZERO_W);
  assign ovf_s      = ((MulDivOp_i == OP_DIV) || (MulDivOp_i == OP_REM)) &&
                      (SrcA_i == MIN_W) && (SrcB_i == ONES_W);
  // funct3 bit1 separates REM/REMU from DIV/DIVU
  assign special_res_s = div_zero_s ? (MulDivOp_i[1] ? SrcA_i : ONES_W)
                                    : (MulDivOp_i[1] ? ZERO_W : SrcA_i);

  // Multiply step: conditional add into the upper half, then shift right with carry
  assign mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {1'b0, ZERO_W});
  assign mul_acc_s  = {mul_sum_s, acc_q[W-1:1]};
  assign mul_prod_s = neg_q ? neg_2w(mul_acc_s) : mul_acc_s;

  // Divide step: remainder needs W+1 bits after the shift; borrow bit decides restore
  assign rem_shift_s = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff_s  = rem_shift_s - {1'b0, mcand_q};
  assign div_ge_s    = ~div_diff_s[W];
  assign div_rem_s   = div_ge_s ? div_diff_s[W-1:0] : rem_shift_s[W-1:0];
  assign div_quo_s   = {acc_q[W-2:0], div_ge_s};
  assign div_res_s   = op_q[1] ? (neg_rem_q ? neg_w(div_rem_s) : div_rem_s)
                               : (neg_q ? neg_w(div_quo_s) : div_quo_s);

  assign busy_o   = ((state_q == IDLE) && start_i && !flush_i) || (state_q == MUL) || (state_q == DIV);
  assign done_o   = done_q;
  assign result_o = result_q;

  // Next-state and datapath update; flush overrides acceptance and completion
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_d      = MulDivOp_i;
            neg_d     = sign_a_s ^ sign_b_s;
            neg_rem_d = sign_a_s;
            cnt_d     = CNT_INIT;
            if (div_zero_s || ovf_s) begin
              result_d = special_res_s;
              done_d   = 1'b1;
              state_d  = DONE;
            end else if (MulDivOp_i[2]) begin
              acc_d   = {ZERO_W, mag_a_s};
              mcand_d = mag_b_s;
              state_d = DIV;
            end else begin
              acc_d   = {ZERO_W, mag_b_s};
              mcand_d = mag_a_s;
              state_d = MUL;
            end
          end else begin
            state_d = IDLE;
          end
        end
        MUL: begin
          acc_d = mul_acc_s;
          if (cnt_q == ZERO_W) begin
            result_d = (op_q == OP_MUL) ? mul_prod_s[W-1:0] : mul_prod_s[2*W-1:W];
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - ONE_W;
          end
        end
        DIV: begin
          acc_d = {div_rem_s, div_quo_s};
          if (cnt_q == ZERO_W) begin
            result_d = div_res_s;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - ONE_W;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= ZERO_W;
      acc_q     <= {ZERO_W, ZERO_W};
      mcand_q   <= ZERO_W;
      op_q      <= 3'b000;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= ZERO_W;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// flush/reset/held-start sequences, and random ops against an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] res;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tv[14];

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
    .MulDivOp_i(op), .SrcA_i(a), .SrcB_i(b),
    .busy_o(busy), .done_o(done), .result_o(res)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic with the RISC-V special-case rules
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy;
    int ix, iy;
    logic ovf;
    sx = longint'($signed(x));
    ix = $signed(x);
    iy = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      3'd1: begin sy = longint'($signed(y)); p = sx * sy; return p[63:32]; end
      3'd2: begin sy = longint'({32'd0, y}); p = sx * sy; return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        return 32'(ix / iy);
      end
      3'd5: begin if (y == 32'd0) return 32'hFFFF_FFFF; return x / y; end
      3'd6: begin
        if (y == 32'd0) return x;
        if (ovf) return 32'd0;
        return 32'(ix % iy);
      end
      default: begin if (y == 32'd0) return x; return x % y; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && ((y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return W + 1;
  endfunction

  // Accept an op in cycle 0 and follow it to done_o (bounded), checking the stall window
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold,
                        output logic [31:0] r, output int lat, output bit busy_ok);
    lat = -1; busy_ok = 1'b1; r = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c; r = res;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r, x, y;
    logic [2:0]  o;
    int          lat, pulses;
    bit          bok;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", res, 32'd0);

    tv[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tv[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tv[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tv[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tv[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    tv[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    tv[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    tv[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    tv[8]  = '{3'd5, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1};
    tv[9]  = '{3'd7, 32'h0000_1234, 32'd0, 32'h0000_1234, 1};
    tv[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tv[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    tv[12] = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    tv[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1};

    for (int i = 0; i < 14; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, 1'b0, r, lat, bok);
      chk($sformatf("vec%0d result", i), r, tv[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("vec%0d busy", i), {31'd0, bok}, 32'd1);
    end

    // start_i held through MUL and DONE must not launch a second op
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, r, lat, bok);
    chk("hold mul result", r, 32'hFFFF_FFEB);
    chk("hold mul latency", 32'(lat), 32'd33);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("hold mul busy after done", {31'd0, busy}, 32'd0);
    count_done(40, pulses);
    chk("hold mul extra done", 32'(pulses), 32'd0);

    run_op(3'd7, 32'h0000_1234, 32'd0, 1'b1, r, lat, bok);
    chk("hold special latency", 32'(lat), 32'd1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("hold special busy after done", {31'd0, busy}, 32'd0);
    count_done(40, pulses);
    chk("hold special extra done", 32'(pulses), 32'd0);

    // Flush at cycle 10 of a MUL
    run_op(3'd5, 32'd100, 32'd7, 1'b0, r, lat, bok);
    chk("pre-flush divu", r, 32'd14);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'h0000_1234; b = 32'h0000_5678;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    count_done(40, pulses);
    chk("flush no done", 32'(pulses), 32'd0);
    chk("flush result kept", res, 32'd14);
    run_op(3'd5, 32'd9, 32'd3, 1'b0, r, lat, bok);
    chk("post-flush divu", r, 32'd3);
    chk("post-flush latency", 32'(lat), 32'd33);

    // Reset at cycle 5 of a DIV
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop reset busy", {31'd0, busy}, 32'd0);
    chk("midop reset done", {31'd0, done}, 32'd0);
    chk("midop reset result", res, 32'd0);
    rst_n = 1'b1;
    count_done(40, pulses);
    chk("midop reset no done", 32'(pulses), 32'd0);

    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      run_op(o, x, y, 1'b0, r, lat, bok);
      chk($sformatf("rand%0d op%0d %h,%h result", i, o, x, y), r, model(o, x, y));
      chk($sformatf("rand%0d op%0d latency", i, o), 32'(lat), 32'(model_lat(o, x, y)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
